// File: rtl/fir_3path_stream_ctrl_if.sv
// Stream and datapath bundle for the 3-path FIR sequencing controller.
//   s_*     : serial Q1.15 sample input stream (valid/ready/last)
//   m_*     : serial result output stream (valid/ready/last)
//   fir_ce  : one-cycle datapath enable, fir_x* lane samples, fir_y* lane results
// master = controller side, slave = environment side (source, sink, datapath).
interface fir_3path_stream_ctrl_if #(
  parameter int DW = 16,
  parameter int YW = 32
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;

  logic          fir_ce;
  logic [DW-1:0] fir_x0;
  logic [DW-1:0] fir_x1;
  logic [DW-1:0] fir_x2;
  logic [YW-1:0] fir_y0;
  logic [YW-1:0] fir_y1;
  logic [YW-1:0] fir_y2;

  logic          m_valid;
  logic          m_ready;
  logic [YW-1:0] m_data;
  logic          m_last;

  modport master (
    input  s_valid, s_data, s_last, m_ready, fir_y0, fir_y1, fir_y2,
    output s_ready, m_valid, m_data, m_last, fir_ce, fir_x0, fir_x1, fir_x2
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, fir_y0, fir_y1, fir_y2,
    input  s_ready, m_valid, m_data, m_last, fir_ce, fir_x0, fir_x1, fir_x2
  );
endinterface

// File: rtl/fir_3path_stream_ctrl.sv
// Sequencing controller for a 3-path parallel FIR datapath whose clock enable
// gates both its shift registers and its output registers.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : master modport; packs the serial sample stream into lane triples,
//           pulses fir_ce once per triple, captures the matching y triple one
//           enable later, serialises it onto m_*, pads partial final triples
//           and flushes the datapath with a zero triple at frame end.
module fir_3path_stream_ctrl #(
  parameter int DW = 16,
  parameter int YW = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fir_3path_stream_ctrl_if.master       bus
);

  typedef enum logic [1:0] {COLLECT, ISSUE, FLUSH} state_e;

  // Tag travelling with an issued triple: valid, lane count (1..3), frame end.
  typedef struct packed {
    logic       vld;
    logic [1:0] cnt;
    logic       last;
  } tag_t;

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [1:0]           cnt_q;
  logic                 last_q;
  logic signed [DW-1:0] lane_q [3];
  logic                 s_ready_q;
  logic                 fir_ce_q;
  tag_t                 tag_q;
  tag_t                 cap_tag_q;
  logic                 cap_pend_q;

  logic [YW-1:0]        obuf_q [3];
  logic                 obuf_vld_q;
  logic [1:0]           ocnt_q;
  logic                 olast_q;
  logic [1:0]           oidx_q;

  logic                 olast_lane;

  assign olast_lane  = (oidx_q == ocnt_q - 2'd1);

  assign bus.s_ready = s_ready_q;
  assign bus.fir_ce  = fir_ce_q;
  assign bus.fir_x0  = lane_q[0];
  assign bus.fir_x1  = lane_q[1];
  assign bus.fir_x2  = lane_q[2];
  assign bus.m_valid = obuf_vld_q;
  assign bus.m_data  = obuf_q[oidx_q];
  assign bus.m_last  = olast_q && olast_lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      idx_q      <= 2'd0;
      cnt_q      <= 2'd0;
      last_q     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        lane_q[i] <= '0;
        obuf_q[i] <= '0;
      end
      s_ready_q  <= 1'b1;
      fir_ce_q   <= 1'b0;
      tag_q      <= '0;
      cap_tag_q  <= '0;
      cap_pend_q <= 1'b0;
      obuf_vld_q <= 1'b0;
      ocnt_q     <= 2'd0;
      olast_q    <= 1'b0;
      oidx_q     <= 2'd0;
    end else begin
      // Stage: lane packing and enable sequencing
      unique case (state_q)
        COLLECT: begin
          if (bus.s_valid && s_ready_q) begin
            lane_q[idx_q] <= bus.s_data;
            idx_q         <= idx_q + 2'd1;
            if (idx_q == 2'd2 || bus.s_last) begin
              cnt_q     <= idx_q + 2'd1;
              last_q    <= bus.s_last;
              // Pad lanes above the final sample so padded outputs are zero-input.
              for (int i = 0; i < 3; i++) begin
                if (i > int'(idx_q)) lane_q[i] <= '0;
              end
              state_q   <= ISSUE;
              s_ready_q <= 1'b0;
            end
          end
        end
        ISSUE, FLUSH: begin
          if (fir_ce_q) begin
            // Enable cycle: the datapath samples fir_x on this edge, so lanes
            // are cleared only now. The y it loads belongs to the previous tag.
            fir_ce_q   <= 1'b0;
            cap_pend_q <= 1'b1;
            cap_tag_q  <= tag_q;
            idx_q      <= 2'd0;
            for (int i = 0; i < 3; i++) lane_q[i] <= '0;
            if (state_q == ISSUE) begin
              tag_q     <= '{vld: 1'b1, cnt: cnt_q, last: last_q};
              state_q   <= last_q ? FLUSH : COLLECT;
              s_ready_q <= !last_q;
            end else begin
              tag_q     <= '0;
              state_q   <= COLLECT;
              s_ready_q <= 1'b1;
            end
          end else if (!obuf_vld_q && !cap_pend_q) begin
            // Only enable when the previous result has somewhere to go.
            fir_ce_q <= 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase

      // Stage: output serialiser
      if (obuf_vld_q && bus.m_ready) begin
        if (olast_lane) begin
          obuf_vld_q <= 1'b0;
          oidx_q     <= 2'd0;
        end else begin
          oidx_q <= oidx_q + 2'd1;
        end
      end

      // Stage: result capture, one cycle after each enable.
      // The buffer is always empty here because enables wait for it.
      if (cap_pend_q) begin
        cap_pend_q <= 1'b0;
        if (cap_tag_q.vld) begin
          obuf_q[0]  <= bus.fir_y0;
          obuf_q[1]  <= bus.fir_y1;
          obuf_q[2]  <= bus.fir_y2;
          obuf_vld_q <= 1'b1;
          ocnt_q     <= cap_tag_q.cnt;
          olast_q    <= cap_tag_q.last;
          oidx_q     <= 2'd0;
        end
      end
    end
  end

endmodule
